// File: rtl/mfcc_fp_pkg.sv
// ---------------------------------------------------------------------------
// mfcc_fp_pkg
//
// Shared constants and types for the FP32 frame statistics blocks.
//
// Contents:
//   FP_EXP_BITS / FP_MAN_BITS - IEEE-754 single-precision field widths
//   FP_ABS_MASK               - clears the sign bit to form |x|
//   FP_POS_INF                - bit pattern of +infinity; also the largest
//                               non-NaN magnitude, so it seeds the running min
//   FP_ZERO                   - bit pattern of +0.0; seeds the running max
//   tracker_state_t           - control states of frame_peak_tracker
// ---------------------------------------------------------------------------
package mfcc_fp_pkg;

    localparam int FP_EXP_BITS = 8;
    localparam int FP_MAN_BITS = 23;

    localparam logic [31:0] FP_ABS_MASK = 32'h7FFF_FFFF;
    localparam logic [31:0] FP_POS_INF  = 32'h7F80_0000;
    localparam logic [31:0] FP_ZERO     = 32'h0000_0000;

    // IDLE waits for start, ACCUM folds samples into the running max/min,
    // HOLD presents the frame result until downstream takes it.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } tracker_state_t;

endpackage : mfcc_fp_pkg

// File: rtl/abs_fp_update.sv
// ---------------------------------------------------------------------------
// abs_fp_update
//
// Purely combinational datapath step for the peak tracker. Takes one FP32
// sample and the current running extremes, and produces the extremes that
// would result from folding that sample in. No state lives here; the parent
// decides whether the results are committed.
//
// Because IEEE-754 magnitudes with the sign bit cleared order the same way
// as unsigned integers, max/min are plain unsigned compares on the abs word.
//
// Ports:
//   sample   in  DATA_WIDTH  raw FP32 input sample
//   cur_max  in  DATA_WIDTH  current running max |x|
//   cur_min  in  DATA_WIDTH  current running min |x|
//   is_nan   out 1           sample is a NaN (exponent all ones, mantissa != 0)
//   new_max  out DATA_WIDTH  updated max (unchanged for NaN or not larger)
//   new_min  out DATA_WIDTH  updated min (unchanged for NaN or not smaller)
// ---------------------------------------------------------------------------
module abs_fp_update
    import mfcc_fp_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] sample,
    input  logic [DATA_WIDTH-1:0] cur_max,
    input  logic [DATA_WIDTH-1:0] cur_min,
    output logic                  is_nan,
    output logic [DATA_WIDTH-1:0] new_max,
    output logic [DATA_WIDTH-1:0] new_min
);

    logic [DATA_WIDTH-1:0] abs_val;
    logic                  exp_all_ones;
    logic                  man_nonzero;

    // Dropping the sign maps -0 onto +0 and -inf onto +inf, so signed zero
    // and both infinities need no special handling below.
    always_comb begin
        abs_val      = sample & DATA_WIDTH'(FP_ABS_MASK);
        exp_all_ones = &abs_val[FP_MAN_BITS +: FP_EXP_BITS];
        man_nonzero  = |abs_val[FP_MAN_BITS-1:0];
        is_nan       = exp_all_ones && man_nonzero;
    end

    // NaNs are kept out of the extremes entirely. Strict compares mean an
    // equal magnitude leaves the register untouched.
    always_comb begin
        new_max = cur_max;
        new_min = cur_min;
        if (!is_nan) begin
            if (abs_val > cur_max) begin
                new_max = abs_val;
            end
            if (abs_val < cur_min) begin
                new_min = abs_val;
            end
        end
    end

endmodule : abs_fp_update

// File: rtl/frame_peak_tracker.sv
// ---------------------------------------------------------------------------
// frame_peak_tracker
//
// Collects FRAME_LEN FP32 samples per frame and reports the largest and
// smallest magnitude seen, plus whether any sample was a NaN. A frame is
// opened with start, filled through a valid/ready input, and the result is
// held on a valid/ready output until taken. abort drops the frame in
// progress (or an untaken result) without reporting anything.
//
// Parameters:
//   DATA_WIDTH  FP word width (IEEE-754 single precision, 32)
//   FRAME_LEN   samples per frame, 2..65535
//   CNT_W       width of the in-frame sample counter
//
// Ports:
//   clk        in   1           clock, everything updates on posedge
//   rst_n      in   1           synchronous active-low reset
//   start      in   1           open a new frame (only looked at in IDLE)
//   abort      in   1           drop current frame and return to IDLE
//   in_valid   in   1           in_data carries a sample
//   in_data    in   DATA_WIDTH  FP32 sample
//   in_ready   out  1           a sample is accepted this cycle if valid
//   out_valid  out  1           frame result available
//   out_ready  in   1           downstream takes the result
//   out_max    out  DATA_WIDTH  largest |sample| of the frame
//   out_min    out  DATA_WIDTH  smallest |sample| of the frame
//   out_nan    out  1           frame contained at least one NaN
//   busy       out  1           tracker is not idle
// ---------------------------------------------------------------------------
module frame_peak_tracker
    import mfcc_fp_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FRAME_LEN  = 256,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_max,
    output logic [DATA_WIDTH-1:0] out_min,
    output logic                  out_nan,
    output logic                  busy
);

    // Index of the final sample; the frame closes on accepting it, so the
    // counter never needs to represent FRAME_LEN itself.
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    localparam logic [DATA_WIDTH-1:0] MAX_SEED = DATA_WIDTH'(FP_ZERO);
    localparam logic [DATA_WIDTH-1:0] MIN_SEED = DATA_WIDTH'(FP_POS_INF);

    tracker_state_t        state;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] run_max;
    logic [DATA_WIDTH-1:0] run_min;
    logic                  run_nan;

    logic                  smp_nan;
    logic [DATA_WIDTH-1:0] nxt_max;
    logic [DATA_WIDTH-1:0] nxt_min;
    logic                  accept;

    // The datapath step always looks at the live input; its results are
    // only committed when a sample is actually accepted.
    abs_fp_update #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_update (
        .sample  (in_data),
        .cur_max (run_max),
        .cur_min (run_min),
        .is_nan  (smp_nan),
        .new_max (nxt_max),
        .new_min (nxt_min)
    );

    // in_ready is registered and only high in ACCUM, so this is the
    // input handshake.
    always_comb begin
        accept = in_valid && in_ready;
    end

    // Single control process: state, counter, running extremes and all
    // registered outputs. The frame result is copied into out_* on the
    // final accept so that out_max/out_min keep the last reported frame
    // while the next frame is being accumulated and while idle. abort is
    // checked before accept/handshake so it always wins; reset wins over
    // everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            run_max   <= MAX_SEED;
            run_min   <= MIN_SEED;
            run_nan   <= 1'b0;
            out_max   <= '0;
            out_min   <= '0;
            out_nan   <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_ACCUM;
                        cnt      <= '0;
                        run_max  <= MAX_SEED;
                        run_min  <= MIN_SEED;
                        run_nan  <= 1'b0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end

                ST_ACCUM: begin
                    if (abort) begin
                        state    <= ST_IDLE;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                    end else if (accept) begin
                        run_max <= nxt_max;
                        run_min <= nxt_min;
                        run_nan <= run_nan | smp_nan;
                        if (cnt == LAST_IDX) begin
                            // Result includes this last sample, visible
                            // the cycle right after it is accepted.
                            state     <= ST_HOLD;
                            out_max   <= nxt_max;
                            out_min   <= nxt_min;
                            out_nan   <= run_nan | smp_nan;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end

                ST_HOLD: begin
                    // start is deliberately not looked at here, even in
                    // the handshake cycle; a new frame needs a fresh start
                    // once back in IDLE.
                    if (abort || out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule : frame_peak_tracker

// File: tb/tb_frame_peak_tracker.sv
// ---------------------------------------------------------------------------
// tb_frame_peak_tracker
//
// Scoreboard bench for frame_peak_tracker with FRAME_LEN=4. The stimulus
// side pushes the expected frame result (computed by a plain reference
// model over the frame's samples) when it issues the last sample; a
// separate monitor compares every cycle the DUT shows out_valid against the
// queue head and pops it when the result is taken or aborted.
// ---------------------------------------------------------------------------
module tb_frame_peak_tracker;

    localparam int DW = 32;
    localparam int FL = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          abort;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_max;
    logic [DW-1:0] out_min;
    logic          out_nan;
    logic          busy;

    typedef logic [31:0] frame_t [FL];

    typedef struct packed {
        logic [31:0] mx;
        logic [31:0] mn;
        logic        nan;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    frame_peak_tracker #(
        .DATA_WIDTH (DW),
        .FRAME_LEN  (FL),
        .CNT_W      (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_max   (out_max),
        .out_min   (out_min),
        .out_nan   (out_nan),
        .busy      (busy)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // One comparison: counts it, reports it if it differs.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    // Reference: magnitude is the word with bit 31 cleared; anything above
    // the +inf pattern is a NaN. NaNs only raise the flag.
    function automatic exp_t model(input frame_t f);
        exp_t        r;
        logic [31:0] a;
        r.mx  = 32'h0000_0000;
        r.mn  = 32'h7F80_0000;
        r.nan = 1'b0;
        foreach (f[i]) begin
            a = f[i] & 32'h7FFF_FFFF;
            if (a > 32'h7F80_0000) begin
                r.nan = 1'b1;
            end else begin
                if (a > r.mx) r.mx = a;
                if (a < r.mn) r.mn = a;
            end
        end
        return r;
    endfunction

    // Random sample biased toward the interesting encodings.
    function automatic logic [31:0] rand_sample();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(7, 0))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'h7F80_0000;
            3:       return 32'hFF80_0000;
            4:       return {r[31], 8'hFF, r[22:1], 1'b1};
            5:       return {r[31], 31'h3F80_0000};
            default: return r;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, "_busy"},      32'(busy),      32'd0);
        checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_in_ready"},  32'(in_ready),  32'd0);
        checkOutput({tag, "_out_max"},   out_max,        32'd0);
        checkOutput({tag, "_out_min"},   out_min,        32'd0);
        checkOutput({tag, "_out_nan"},   32'(out_nan),   32'd0);
    endtask

    // Monitor: every cycle a result is shown it must match the queue head
    // (which also proves stability across HOLD). The head is retired when
    // the result is taken or dropped by abort.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_result: actual out_valid=1 required no pending frame");
            end else begin
                checkOutput("out_max", out_max,       exp_q[0].mx);
                checkOutput("out_min", out_min,       exp_q[0].mn);
                checkOutput("out_nan", 32'(out_nan),  32'(exp_q[0].nan));
                if (out_ready || abort) begin
                    exp_q.delete(0);
                end
            end
        end
    end

    // Runs one full frame: start, FL samples with gaps of gap_min..gap_max
    // idle cycles, then hold_cycles of back-pressure before release.
    task automatic applyStimulus(input frame_t f, input int gap_min, input int gap_max,
                                 input int hold_cycles, input bit start_during,
                                 input bit abort_in_hold);
        int gaps;
        bit got;
        start = 1'b1;
        tick();
        if (!start_during) start = 1'b0;
        checkOutput("busy_after_start", 32'(busy), 32'd1);
        for (int k = 0; k < FL; k++) begin
            gaps = int'($urandom_range(gap_max, gap_min));
            in_valid = 1'b0;
            repeat (gaps) tick();
            in_valid = 1'b1;
            in_data  = f[k];
            checkOutput("in_ready_accum", 32'(in_ready), 32'd1);
            if (k == FL - 1) begin
                checkOutput("valid_not_early", 32'(out_valid), 32'd0);
                exp_q.push_back(model(f));
            end
            tick();
        end
        in_valid = 1'b0;
        in_data  = $urandom;
        checkOutput("valid_latency", 32'(out_valid), 32'd1);
        checkOutput("in_ready_hold", 32'(in_ready), 32'd0);
        repeat (hold_cycles) tick();
        if (abort_in_hold) begin
            abort     = 1'b1;
            out_ready = 1'($urandom_range(1, 0));
            tick();
            abort     = 1'b0;
            out_ready = 1'b0;
        end else begin
            out_ready = 1'b1;
            got = 1'b0;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                if (out_valid && out_ready) got = 1'b1;
            end
            n_checks++;
            if (!got) begin
                n_fail++;
                $display("[TB] FAIL handshake_timeout: actual no handshake in 20 cycles required handshake");
            end
            tick();
            out_ready = 1'b0;
        end
        start = 1'b0;
        checkOutput("valid_after_release", 32'(out_valid), 32'd0);
        checkOutput("busy_after_release",  32'(busy),      32'd0);
        tick();
        checkOutput("busy_stays_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        frame_t f_a, f_b, f_c, f_r;

        f_a = '{32'hC040_0000, 32'h3F80_0000, 32'h40A0_0000, 32'hBF00_0000};
        f_b = '{32'h7FC0_0000, 32'h8000_0000, 32'hFF80_0000, 32'h4120_0000};
        f_c = '{32'h7FC0_0001, 32'h7FC0_0001, 32'h7FC0_0001, 32'h7FC0_0001};

        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        tick();
        tick();
        checkIdleZero("por");
        rst_n = 1'b1;
        tick();

        $display("[TB] directed frames");
        applyStimulus(f_a, 0, 0, 0, 1'b0, 1'b0);
        applyStimulus(f_a, 1, 1, 5, 1'b0, 1'b0);
        applyStimulus(f_b, 0, 0, 1, 1'b0, 1'b0);
        applyStimulus(f_c, 0, 2, 0, 1'b0, 1'b0);

        $display("[TB] abort after two accepts, abort beating an accept");
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_data  = f_b[k];
            tick();
        end
        in_valid = 1'b1;
        in_data  = f_b[2];
        abort    = 1'b1;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        checkOutput("abort_busy",      32'(busy),      32'd0);
        checkOutput("abort_in_ready",  32'(in_ready),  32'd0);
        checkOutput("abort_out_valid", 32'(out_valid), 32'd0);
        applyStimulus(f_a, 0, 1, 1, 1'b0, 1'b0);

        $display("[TB] abort while holding a result");
        applyStimulus(f_b, 0, 0, 2, 1'b0, 1'b1);

        $display("[TB] reset after three accepts");
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = f_a[k];
            tick();
        end
        rst_n = 1'b0;
        start = 1'b1;
        abort = 1'b1;
        tick();
        checkIdleZero("mid_reset");
        rst_n    = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        in_valid = 1'b0;
        tick();
        checkOutput("post_reset_busy", 32'(busy), 32'd0);

        $display("[TB] start held through ACCUM and HOLD handshake");
        applyStimulus(f_a, 0, 1, 2, 1'b1, 1'b0);

        $display("[TB] random frames");
        for (int n = 0; n < 40; n++) begin
            foreach (f_r[i]) f_r[i] = rand_sample();
            applyStimulus(f_r, 0, 2, int'($urandom_range(3, 0)),
                          1'($urandom_range(1, 0)),
                          ($urandom_range(9, 0) == 0));
        end

        repeat (3) tick();
        checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_frame_peak_tracker
